cache_fence_seq: RTL and testbench

CACHE_FENCE_SEQ -- requirements
Module: cache_fence_seq

---
 rtl/wt_cache_pkg.sv | 18 +
 rtl/cache_fence_seq_if.sv | 33 +++
 rtl/cache_fence_seq.sv | 101 ++++++++++
 tb/tb_cache_fence_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wt_cache_pkg
// Brief    : Shared types for the write-through cache subsystem.
// Revision : 1.0 - initial release
// ============================================================================
package wt_cache_pkg;

  typedef enum logic [2:0] {
    FS_IDLE     = 3'd0,
    FS_DFLUSH   = 3'd1,
    FS_WB_DRAIN = 3'd2,
    FS_IFLUSH   = 3'd3,
    FS_DONE     = 3'd4
  } fence_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/cache_fence_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_fence_seq_if
// Brief    : Controller <-> fence sequencer signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_fence_seq_if #(
  parameter int unsigned LAT_W = 16
) ();

  logic             fence;
  logic             fencei;
  logic             dcache_flush;
  logic             dcache_flush_ack;
  logic             wbuffer_empty;
  logic             icache_flush;
  logic             stall;
  logic             done;
  logic [LAT_W-1:0] last_lat;

  // Controller / cache side: issues requests and status, observes the sequence
  modport master (
    output fence, fencei, dcache_flush_ack, wbuffer_empty,
    input  dcache_flush, icache_flush, stall, done, last_lat
  );

  modport slave (
    input  fence, fencei, dcache_flush_ack, wbuffer_empty,
    output dcache_flush, icache_flush, stall, done, last_lat
  );

endinterface
`default_nettype wire

// File: rtl/cache_fence_seq.sv
`default_nettype none
// ============================================================================
// Module   : cache_fence_seq
// Brief    : fence / fence.i sequencer: D$ flush, write-buffer drain, I$ flush.
// Revision : 1.0 - initial release
// ============================================================================
module cache_fence_seq
  import wt_cache_pkg::*;
#(
  parameter bit          FlushDcacheOnFence = 1'b1,
  parameter int unsigned LatW               = 16
) (
  input  wire             clk_i,
  input  wire             rst_ni,
  input  wire             fence_i,
  input  wire             fence_i_i,
  output logic            dcache_flush_o,
  input  wire             dcache_flush_ack_i,
  input  wire             wbuffer_empty_i,
  output logic            icache_flush_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [LatW-1:0] last_lat_o
);

  fence_seq_state_e state_q, state_d;
  logic             is_fencei_q, is_fencei_d;
  logic [LatW-1:0]  lat_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= FS_IDLE;
      is_fencei_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_fencei_q <= is_fencei_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    is_fencei_d    = is_fencei_q;
    dcache_flush_o = 1'b0;
    icache_flush_o = 1'b0;
    stall_o        = 1'b1;
    done_o         = 1'b0;
    unique case (state_q)
      FS_IDLE: begin
        stall_o = 1'b0;
        // fence.i wins when both requests arrive together
        if (fence_i_i) begin
          is_fencei_d = 1'b1;
          state_d     = FS_DFLUSH;
        end else if (fence_i) begin
          is_fencei_d = 1'b0;
          state_d     = FlushDcacheOnFence ? FS_DFLUSH : FS_WB_DRAIN;
        end
      end
      FS_DFLUSH: begin
        dcache_flush_o = 1'b1;
        if (dcache_flush_ack_i) state_d = FS_WB_DRAIN;
      end
      FS_WB_DRAIN: begin
        if (wbuffer_empty_i) state_d = is_fencei_q ? FS_IFLUSH : FS_DONE;
      end
      FS_IFLUSH: begin
        icache_flush_o = 1'b1;
        state_d        = FS_DONE;
      end
      FS_DONE: begin
        done_o  = 1'b1;
        state_d = FS_IDLE;
      end
      default: begin
        stall_o = 1'b0;
        state_d = FS_IDLE;
      end
    endcase
  end

  // Counter value in state cycle k equals k, so the DONE-cycle value is the full latency
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lat_cnt_q <= '0;
    end else if (state_q == FS_IDLE) begin
      if (state_d != FS_IDLE) lat_cnt_q <= LatW'(1);
    end else if (lat_cnt_q != {LatW{1'b1}}) begin
      lat_cnt_q <= lat_cnt_q + LatW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_lat_o <= '0;
    end else if (state_q == FS_DONE) begin
      last_lat_o <= lat_cnt_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_fence_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_fence_seq
// Brief    : Three sequencer variants (flush-on-fence, no flush, 4-bit latency)
//            driven by shared stimulus and checked against a latency model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_fence_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic fence, fencei, ack, wbe;

  int checks = 0;
  int errors = 0;
  int cur_cycle;
  bit mon_en = 1'b0;
  int n_dfl[3], n_ifl[3], n_stl[3], n_done[3], done_cyc[3];

  always #5 clk = ~clk;

  cache_fence_seq_if #(.LAT_W(16)) bus_a ();
  cache_fence_seq_if #(.LAT_W(16)) bus_b ();
  cache_fence_seq_if #(.LAT_W(4))  bus_c ();

  assign bus_a.fence = fence;  assign bus_a.fencei = fencei;
  assign bus_a.dcache_flush_ack = ack;  assign bus_a.wbuffer_empty = wbe;
  assign bus_b.fence = fence;  assign bus_b.fencei = fencei;
  assign bus_b.dcache_flush_ack = ack;  assign bus_b.wbuffer_empty = wbe;
  assign bus_c.fence = fence;  assign bus_c.fencei = fencei;
  assign bus_c.dcache_flush_ack = ack;  assign bus_c.wbuffer_empty = wbe;

  cache_fence_seq #(.FlushDcacheOnFence(1'b1), .LatW(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .fence_i(bus_a.fence), .fence_i_i(bus_a.fencei),
    .dcache_flush_o(bus_a.dcache_flush), .dcache_flush_ack_i(bus_a.dcache_flush_ack),
    .wbuffer_empty_i(bus_a.wbuffer_empty), .icache_flush_o(bus_a.icache_flush),
    .stall_o(bus_a.stall), .done_o(bus_a.done), .last_lat_o(bus_a.last_lat));

  cache_fence_seq #(.FlushDcacheOnFence(1'b0), .LatW(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .fence_i(bus_b.fence), .fence_i_i(bus_b.fencei),
    .dcache_flush_o(bus_b.dcache_flush), .dcache_flush_ack_i(bus_b.dcache_flush_ack),
    .wbuffer_empty_i(bus_b.wbuffer_empty), .icache_flush_o(bus_b.icache_flush),
    .stall_o(bus_b.stall), .done_o(bus_b.done), .last_lat_o(bus_b.last_lat));

  cache_fence_seq #(.FlushDcacheOnFence(1'b1), .LatW(4)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .fence_i(bus_c.fence), .fence_i_i(bus_c.fencei),
    .dcache_flush_o(bus_c.dcache_flush), .dcache_flush_ack_i(bus_c.dcache_flush_ack),
    .wbuffer_empty_i(bus_c.wbuffer_empty), .icache_flush_o(bus_c.icache_flush),
    .stall_o(bus_c.stall), .done_o(bus_c.done), .last_lat_o(bus_c.last_lat));

  logic [2:0]  dfl, ifl, stl, dn;
  logic [15:0] lat_a, lat_b;
  logic [3:0]  lat_c;
  assign dfl = {bus_c.dcache_flush, bus_b.dcache_flush, bus_a.dcache_flush};
  assign ifl = {bus_c.icache_flush, bus_b.icache_flush, bus_a.icache_flush};
  assign stl = {bus_c.stall, bus_b.stall, bus_a.stall};
  assign dn  = {bus_c.done, bus_b.done, bus_a.done};
  assign lat_a = bus_a.last_lat;
  assign lat_b = bus_b.last_lat;
  assign lat_c = bus_c.last_lat;

  function automatic int lat_of(input int d);
    return (d == 0) ? int'(lat_a) : (d == 1) ? int'(lat_b) : int'(lat_c);
  endfunction

  // Reference model. Request in cycle 0; ack pulse in cycle a; write buffer
  // empty from cycle e on. D$ phase occupies cycles 1..a when flushing, drain
  // ends at the first empty cycle, then optional I$ cycle, then DONE.
  function automatic int exp_lat(input int d, input int kind, input int a, input int e);
    bit fi;
    bit fl;
    int drain_start;
    int drain_end;
    fi = (kind != 0);
    fl = fi || (d != 1);
    drain_start = fl ? a + 1 : 1;
    drain_end = (e > drain_start) ? e : drain_start;
    return drain_end + (fi ? 1 : 0) + 1;
  endfunction

  function automatic int sat_lat(input int d, input int l);
    int mx;
    mx = (d == 2) ? 15 : 65535;
    return (l > mx) ? mx : l;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        if (dfl[d]) n_dfl[d]++;
        if (ifl[d]) n_ifl[d]++;
        if (stl[d]) n_stl[d]++;
        if (dn[d]) begin
          n_done[d]++;
          done_cyc[d] = cur_cycle;
        end
      end
    end
  end

  task automatic mon_clear();
    for (int d = 0; d < 3; d++) begin
      n_dfl[d] = 0; n_ifl[d] = 0; n_stl[d] = 0; n_done[d] = 0; done_cyc[d] = -1;
    end
  endtask

  // kind: 0 = fence, 1 = fence.i, 2 = both. inj1/inj2: extra fence cycles (-1 = none).
  task automatic drive_seq(input int kind, input int a, input int e,
                           input int inj1, input int inj2, input int ncyc);
    mon_clear();
    mon_en = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      cur_cycle = c;
      fence  = (c == 0 && kind != 1) || c == inj1 || c == inj2;
      fencei = (c == 0 && kind != 0);
      ack    = (c == a);
      wbe    = (c >= e);
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    fence = 1'b0; fencei = 1'b0; ack = 1'b0; wbe = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fence = 1'b0; fencei = 1'b0; ack = 1'b0; wbe = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({dfl[d], ifl[d], stl[d], dn[d]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %b, expected 0000", d, {dfl[d], ifl[d], stl[d], dn[d]});
      end
      checks++;
      if (lat_of(d) !== 0) begin
        errors++;
        $display("FAIL reset_last_lat dut%0d: got %0d, expected 0", d, lat_of(d));
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_min_latency();
    drive_seq(0, 1, 0, -1, -1, 5);
    checks++;
    if (done_cyc[1] !== 2 || lat_of(1) !== 2) begin
      errors++;
      $display("FAIL min_latency dut1: done cycle %0d lat %0d, expected 2 and 2", done_cyc[1], lat_of(1));
    end
  endtask

  task automatic test_fencei_flush();
    drive_seq(1, 3, 0, -1, -1, 9);
    checks++;
    if (n_dfl[0] !== 3 || n_ifl[0] !== 1 || n_done[0] !== 1) begin
      errors++;
      $display("FAIL fencei_flush dut0: dflush %0d iflush %0d done %0d, expected 3 1 1", n_dfl[0], n_ifl[0], n_done[0]);
    end
    checks++;
    if (lat_of(0) !== 6 || lat_of(2) !== 6) begin
      errors++;
      $display("FAIL fencei_lat: got %0d/%0d, expected 6/6", lat_of(0), lat_of(2));
    end
  endtask

  task automatic test_fence_drain();
    drive_seq(0, 2, 6, -1, -1, 10);
    checks++;
    if (n_dfl[1] !== 0 || n_ifl[1] !== 0 || n_done[1] !== 1) begin
      errors++;
      $display("FAIL fence_drain dut1: dflush %0d iflush %0d done %0d, expected 0 0 1", n_dfl[1], n_ifl[1], n_done[1]);
    end
    checks++;
    if (lat_of(1) !== 7) begin
      errors++;
      $display("FAIL fence_drain_lat dut1: got %0d, expected 7", lat_of(1));
    end
  endtask

  task automatic test_both_requests();
    drive_seq(2, 2, 0, -1, -1, 8);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (n_ifl[d] !== 1 || n_done[d] !== 1) begin
        errors++;
        $display("FAIL both_requests dut%0d: iflush %0d done %0d, expected 1 1", d, n_ifl[d], n_done[d]);
      end
    end
  endtask

  task automatic test_ignore_requests();
    int l;
    l = exp_lat(0, 1, 4, 0);
    drive_seq(1, 4, 0, 2, l, l + 5);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (n_done[d] !== 1 || done_cyc[d] !== l || n_stl[d] !== l || stl[d] !== 1'b0) begin
        errors++;
        $display("FAIL ignore_requests dut%0d: done %0d at %0d stall %0d now %b, expected 1 at %0d stall %0d now 0",
                 d, n_done[d], done_cyc[d], n_stl[d], stl[d], l, l);
      end
    end
  endtask

  task automatic test_saturate();
    drive_seq(1, 21, 0, -1, -1, 26);
    checks++;
    if (lat_of(2) !== 15 || lat_of(0) !== 24) begin
      errors++;
      $display("FAIL saturate: got %0d/%0d, expected 15/24", lat_of(2), lat_of(0));
    end
  endtask

  // Each sequence starts in the cycle right after the previous DONE
  task automatic test_back_to_back_random();
    for (int it = 0; it < 30; it++) begin
      int kind, a, e, lmax, l, edfl;
      kind = int'($urandom_range(2, 0));
      a    = int'($urandom_range(8, 1));
      e    = int'($urandom_range(10, 0));
      lmax = exp_lat(0, kind, a, e);
      drive_seq(kind, a, e, -1, -1, lmax + 1);
      for (int d = 0; d < 3; d++) begin
        l = exp_lat(d, kind, a, e);
        edfl = (kind != 0 || d != 1) ? a : 0;
        checks++;
        if (n_dfl[d] !== edfl || n_ifl[d] !== ((kind != 0) ? 1 : 0)) begin
          errors++;
          $display("FAIL rand_flush it%0d dut%0d: dflush %0d iflush %0d, expected %0d %0d",
                   it, d, n_dfl[d], n_ifl[d], edfl, (kind != 0) ? 1 : 0);
        end
        checks++;
        if (n_done[d] !== 1 || done_cyc[d] !== l || n_stl[d] !== l) begin
          errors++;
          $display("FAIL rand_done it%0d dut%0d: done %0d at %0d stall %0d, expected 1 at %0d stall %0d",
                   it, d, n_done[d], done_cyc[d], n_stl[d], l, l);
        end
        checks++;
        if (lat_of(d) !== sat_lat(d, l)) begin
          errors++;
          $display("FAIL rand_lat it%0d dut%0d: got %0d, expected %0d", it, d, lat_of(d), sat_lat(d, l));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    mon_clear();
    mon_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cur_cycle = c;
      fencei = (c == 0); ack = 1'b0; wbe = 1'b1;
      @(posedge clk); #1;
    end
    fencei = 1'b0;
    checks++;
    if (dfl !== 3'b111) begin
      errors++;
      $display("FAIL reset_mid_pre: dflush %b, expected 111", dfl);
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({dfl[d], stl[d], ifl[d], dn[d]} !== 4'b0000 || lat_of(d) !== 0) begin
        errors++;
        $display("FAIL reset_mid_async dut%0d: outs %b lat %0d, expected 0000 0", d, {dfl[d], stl[d], ifl[d], dn[d]}, lat_of(d));
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 2; c < 12; c++) begin
      cur_cycle = c;
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (n_done[d] !== 0 || lat_of(d) !== 0 || stl[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_after dut%0d: done %0d lat %0d stall %b, expected 0 0 0", d, n_done[d], lat_of(d), stl[d]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_min_latency();
    test_fencei_flush();
    test_fence_drain();
    test_both_requests();
    test_ignore_requests();
    test_saturate();
    test_back_to_back_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
